// File: rtl/bubsysrom_video_pkg.sv
// Shared ranges, pattern enum and helpers for the GX400 video timing source.
// Counters, active window, sync windows and BGR555 field offsets.
package bubsysrom_video_pkg;

  localparam logic [8:0] H_MIN = 9'd128;
  localparam logic [8:0] H_MAX = 9'd511;
  localparam logic [8:0] V_MIN = 9'd248;
  localparam logic [8:0] V_MAX = 9'd511;

  localparam logic [8:0] H_ACT_START = 9'd278;
  localparam logic [8:0] H_ACT_END   = 9'd149;
  localparam logic [8:0] V_ACT_START = 9'd272;
  localparam logic [8:0] V_ACT_END   = 9'd495;
  localparam logic [8:0] V_INC_H     = 9'd176;

  localparam logic [8:0] HSYNC_START = 9'd192;
  localparam logic [8:0] HSYNC_END   = 9'd223;
  localparam logic [8:0] VSYNC_START = 9'd504;

  localparam logic [8:0] FE_H = 9'd151;
  localparam logic [8:0] FE_V = 9'd495;

  // x offset for H below the active start: the line is 384 ticks
  // long, so H+384-278 == H+106.
  localparam logic [8:0] H_X_OFS = 9'd106;

  localparam int BGR_R = 0;
  localparam int BGR_G = 5;
  localparam int BGR_B = 10;

  typedef enum logic [1:0] {
    PAT_PALETTE = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_GRAD    = 2'd2,
    PAT_SOLID   = 2'd3
  } pat_sel_e;

  function automatic logic [8:0] h_next(
    input logic [8:0] h
  );
    return (h == H_MAX) ? H_MIN : h + 9'd1;
  endfunction

  function automatic logic [8:0] v_next(
    input logic [8:0] v
  );
    return (v == V_MAX) ? V_MIN : v + 9'd1;
  endfunction

  // H only spans 128..511, so the active line is the
  // union of the two ends of the counter.
  function automatic logic h_act(
    input logic [8:0] h
  );
    return (h >= H_ACT_START) || (h <= H_ACT_END);
  endfunction

  function automatic logic v_act(
    input logic [8:0] v
  );
    return (v >= V_ACT_START) && (v <= V_ACT_END);
  endfunction

  function automatic logic [7:0] pix_x(
    input logic [8:0] h
  );
    return 8'((h >= H_ACT_START) ?
              h - H_ACT_START : h + H_X_OFS);
  endfunction

  function automatic logic [7:0] pix_y(
    input logic [8:0] v
  );
    return 8'(v - V_ACT_START);
  endfunction

endpackage

// File: rtl/bubsysrom_video_timing_src_if.sv
// Palette fetch bus: look-ahead coordinate out, BGR555 data back.
// master = timing source, slave = palette/mixer.
interface bubsysrom_video_timing_src_if;
  logic [7:0]  FETCH_X;
  logic [7:0]  FETCH_Y;
  logic        FETCH_ACTIVE;
  logic [14:0] PIXELDATA;

  modport master (
    output FETCH_X,
    output FETCH_Y,
    output FETCH_ACTIVE,
    input  PIXELDATA
  );

  modport slave (
    input  FETCH_X,
    input  FETCH_Y,
    input  FETCH_ACTIVE,
    output PIXELDATA
  );
endinterface

// File: rtl/bubsysrom_testpattern.sv
// Combinational test-pattern mux: x/y (upper 5 bits), select -> BGR555.
// In: i_SEL, i_X5, i_Y5, i_PIXELDATA, i_SOLID_COLOR. Out: o_BGR.
module bubsysrom_testpattern
  import bubsysrom_video_pkg::*;
(
  input  pat_sel_e    i_SEL,
  input  logic [4:0]  i_X5,
  input  logic [4:0]  i_Y5,
  input  logic [14:0] i_PIXELDATA,
  input  logic [14:0] i_SOLID_COLOR,
  output logic [14:0] o_BGR
);

  logic [2:0] w_bar;
  assign w_bar = i_X5[4:2];

  always_comb begin
    o_BGR = '0;
    unique case (i_SEL)
      PAT_PALETTE: o_BGR = i_PIXELDATA;
      PAT_BARS: begin
        o_BGR[BGR_R +: 5] = {5{w_bar[0]}};
        o_BGR[BGR_G +: 5] = {5{w_bar[1]}};
        o_BGR[BGR_B +: 5] = {5{w_bar[2]}};
      end
      PAT_GRAD: begin
        o_BGR[BGR_R +: 5] = i_X5;
        o_BGR[BGR_G +: 5] = i_Y5;
        o_BGR[BGR_B +: 5] = i_X5 ^ i_Y5;
      end
      PAT_SOLID: o_BGR = i_SOLID_COLOR;
    endcase
  end

endmodule

// File: rtl/bubsysrom_video_timing_src.sv
// GX400 video transmit timing: H/V counters, blank, sync, BGR555 word.
// Clk/reset/pixel-enable, pattern controls, fetch bus, video outputs.
module bubsysrom_video_timing_src
  import bubsysrom_video_pkg::*;
(
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST_n,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic [1:0]  i_PATTERN_SEL,
  input  logic [14:0] i_SOLID_COLOR,
  bubsysrom_video_timing_src_if.master fetch_if,
  output logic [8:0]  o_HCOUNTER,
  output logic [8:0]  o_VCOUNTER,
  output logic        o_HBLANK_n,
  output logic        o_VBLANK_n,
  output logic        o_HSYNC_n,
  output logic        o_VSYNC_n,
  output logic [15:0] o_VIDEODATA,
  output logic        o_FRAMEEND,
  output logic [15:0] o_FRAMECNT
);

  logic [8:0]  r_h, r_v;
  logic        r_hb_n, r_vb_n, r_hs_n, r_vs_n;
  logic [15:0] r_vid;
  logic [7:0]  r_fx, r_fy;
  logic        r_fa, r_fe;
  logic [15:0] r_fcnt;

  logic        w_tick;
  logic [8:0]  w_h1, w_v1, w_h2, w_v2;
  logic        w_act, w_fe;
  logic [4:0]  w_x5, w_y5;
  logic [14:0] w_bgr;
  pat_sel_e    w_sel;

  assign w_tick = ~i_EMU_CLK6MPCEN_n;
  assign w_sel  = pat_sel_e'(i_PATTERN_SEL);

  // w_h1/w_v1: lead position, the pixel the outputs show next.
  // w_h2/w_v2: the pixel after that, issued as the fetch so its
  // palette data is back by the tick that displays it.
  always_comb begin
    w_h1 = h_next(r_h);
    w_v1 = (w_h1 == V_INC_H) ? v_next(r_v) : r_v;
    w_h2 = h_next(w_h1);
    w_v2 = (w_h2 == V_INC_H) ? v_next(w_v1) : w_v1;
  end

  assign w_act = h_act(w_h1) && v_act(w_v1);
  assign w_fe  = (w_h1 == FE_H) && (w_v1 == FE_V);
  assign w_x5  = 5'(pix_x(w_h1) >> 3);
  assign w_y5  = 5'(pix_y(w_v1) >> 3);

  bubsysrom_testpattern u_pat (
    .i_SEL        (w_sel),
    .i_X5         (w_x5),
    .i_Y5         (w_y5),
    .i_PIXELDATA  (fetch_if.PIXELDATA),
    .i_SOLID_COLOR(i_SOLID_COLOR),
    .o_BGR        (w_bgr)
  );

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      r_h    <= H_MIN;
      r_v    <= V_MIN;
      r_hb_n <= 1'b0;
      r_vb_n <= 1'b0;
      r_hs_n <= 1'b1;
      r_vs_n <= 1'b1;
      r_vid  <= '0;
      r_fx   <= '0;
      r_fy   <= '0;
      r_fa   <= 1'b0;
      r_fe   <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_fe <= w_tick && w_fe;
      if (w_tick) begin
        r_h    <= w_h1;
        r_v    <= w_v1;
        r_hb_n <= h_act(w_h1);
        r_vb_n <= v_act(w_v1);
        r_hs_n <= !((w_h1 >= HSYNC_START) &&
                    (w_h1 <= HSYNC_END));
        // vsync window runs to the top of the counter
        r_vs_n <= !(w_v1 >= VSYNC_START);
        r_vid  <= w_act ? {1'b0, w_bgr} : 16'd0;
        r_fx   <= pix_x(w_h2);
        r_fy   <= pix_y(w_v2);
        r_fa   <= h_act(w_h2) && v_act(w_v2);
        if (w_fe) r_fcnt <= r_fcnt + 16'd1;
      end
    end
  end

  assign o_HCOUNTER            = r_h;
  assign o_VCOUNTER            = r_v;
  assign o_HBLANK_n            = r_hb_n;
  assign o_VBLANK_n            = r_vb_n;
  assign o_HSYNC_n             = r_hs_n;
  assign o_VSYNC_n             = r_vs_n;
  assign o_VIDEODATA           = r_vid;
  assign o_FRAMEEND            = r_fe;
  assign o_FRAMECNT            = r_fcnt;
  assign fetch_if.FETCH_X      = r_fx;
  assign fetch_if.FETCH_Y      = r_fy;
  assign fetch_if.FETCH_ACTIVE = r_fa;

endmodule

// File: tb/tb_bubsysrom_video_timing_src.sv
// Randomized bench for bubsysrom_video_timing_src.
// Pixel-index model of the raster checked every MCLK.
module tb_bubsysrom_video_timing_src;

  localparam int LINE  = 384;
  localparam int FRAME = 101376;
  localparam int FE_P  = 94871;
  localparam int END1  = 97980;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_n = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [14:0] solid = 15'd0;

  logic [8:0]  hc, vc;
  logic        hb_n, vb_n, hs_n, vs_n;
  logic [15:0] vd;
  logic        fe;
  logic [15:0] fc;

  bubsysrom_video_timing_src_if fif();

  // palette stand-in: data depends only on the issued fetch
  assign fif.PIXELDATA = {fif.FETCH_Y[4:0],
                          fif.FETCH_X[4:0],
                          fif.FETCH_X[4:0]};

  bubsysrom_video_timing_src dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_INITRST_n  (rst_n),
    .i_EMU_CLK6MPCEN_n(en_n),
    .i_PATTERN_SEL    (sel),
    .i_SOLID_COLOR    (solid),
    .fetch_if         (fif.master),
    .o_HCOUNTER       (hc),
    .o_VCOUNTER       (vc),
    .o_HBLANK_n       (hb_n),
    .o_VBLANK_n       (vb_n),
    .o_HSYNC_n        (hs_n),
    .o_VSYNC_n        (vs_n),
    .o_VIDEODATA      (vd),
    .o_FRAMEEND       (fe),
    .o_FRAMECNT       (fc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int p;
  bit ticked;
  int exp_video;

  // p = pixel ticks since reset; position is pure arithmetic
  function automatic int hpos(int q);
    return 128 + q % LINE;
  endfunction

  // V steps each time H enters 176, i.e. q%384 == 48
  function automatic int vpos(int q);
    return 248 + ((q + 336) / LINE) % 264;
  endfunction

  function automatic bit hact(int h);
    return (h >= 278) || (h <= 149);
  endfunction

  function automatic bit vact(int v);
    return (v >= 272) && (v <= 495);
  endfunction

  function automatic int xof(int h);
    return ((h - 278 + LINE) % LINE) % 256;
  endfunction

  function automatic int yof(int v);
    return (v - 272 + 512) % 256;
  endfunction

  function automatic int vid(int q, int s, int sc);
    int h, v, x, y, b;
    h = hpos(q);
    v = vpos(q);
    if (!(hact(h) && vact(v))) return 0;
    x = xof(h);
    y = yof(v);
    case (s)
      0: return (y % 32) * 1024 + (x % 32) * 32 + x % 32;
      1: begin
        b = x / 32;
        return ((b / 4) % 2) * 31 * 1024 +
               ((b / 2) % 2) * 31 * 32 + (b % 2) * 31;
      end
      2: return ((x / 8) ^ (y / 8)) * 1024 +
                (y / 8) * 32 + x / 8;
      default: return sc;
    endcase
  endfunction

  function automatic int gap(int q);
    if (q < 16) return 8;
    if (q >= FE_P - 5 && q < FE_P + 5) return 4;
    return 1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (p=%0d)",
               nm, act, exp, p);
    end
  endtask

  task automatic check_all(bit tick_now);
    int h, v, fh, fv, efx, efy, efa, efc;
    h = hpos(p);
    v = vpos(p);
    efx = 0; efy = 0; efa = 0;
    if (ticked) begin
      fh = hpos(p + 1);
      fv = vpos(p + 1);
      efx = xof(fh);
      efy = yof(fv);
      efa = int'(hact(fh) && vact(fv));
    end
    efc = (p >= FE_P) ? 1 + (p - FE_P) / FRAME : 0;
    chk("hcnt", int'(hc), h);
    chk("vcnt", int'(vc), v);
    chk("hblank_n", int'(hb_n), ticked ? int'(hact(h)) : 0);
    chk("vblank_n", int'(vb_n), ticked ? int'(vact(v)) : 0);
    chk("hsync_n", int'(hs_n), int'(!(h >= 192 && h <= 223)));
    chk("vsync_n", int'(vs_n), int'(!(v >= 504)));
    chk("video", int'(vd), exp_video);
    chk("fetch_x", int'(fif.FETCH_X), efx);
    chk("fetch_y", int'(fif.FETCH_Y), efy);
    chk("fetch_act", int'(fif.FETCH_ACTIVE), efa);
    chk("frameend", int'(fe),
        int'(tick_now && (p % FRAME == FE_P)));
    chk("framecnt", int'(fc), efc);
  endtask

  // hand-computed points that pin the model itself
  task automatic pins();
    if (p == 1) begin
      chk("first_h", int'(hc), 129);
      chk("first_v", int'(vc), 248);
    end
    if (p == 47) chk("v_pre176", int'(vc), 248);
    if (p == 48) begin
      chk("h_176", int'(hc), 176);
      chk("v_at176", int'(vc), 249);
    end
    if (p == 384) chk("line_len_h", int'(hc), 128);
    if (p == 63) chk("hsync_191", int'(hs_n), 1);
    if (p == 64) chk("hsync_192", int'(hs_n), 0);
    if (p == 95) chk("hsync_223", int'(hs_n), 0);
    if (p == 96) chk("hsync_224", int'(hs_n), 1);
    if (p == 12076) begin
      chk("pal_h", int'(hc), 300);
      chk("pal_v", int'(vc), 280);
      chk("pal_video", int'(vd), 'h22D6);
    end
    if (p == 19733) chk("bar_h277", int'(vd), 0);
    if (p == 19734) begin
      chk("bar_h278_h", int'(hc), 278);
      chk("bar_v300", int'(vc), 300);
      chk("bar_h278", int'(vd), 0);
    end
    if (p == 19766) chk("bar_h310", int'(vd), 'h001F);
    if (p == 19968) chk("bar_h128", int'(vd), 'h7FFF);
    if (p == 19989) chk("bar_h149", int'(vd), 'h7FFF);
    if (p == 19990) chk("bar_h150", int'(vd), 0);
    if (p == FE_P) begin
      chk("fe_pulse", int'(fe), 1);
      chk("fe_h", int'(hc), 151);
      chk("fe_v", int'(vc), 495);
      chk("fe_cnt", int'(fc), 1);
    end
    if (p == 94895) chk("vblank_495", int'(vb_n), 1);
    if (p == 94896) chk("vblank_496", int'(vb_n), 0);
    if (p == 97967) chk("vsync_503", int'(vs_n), 1);
    if (p == 97968) begin
      chk("vsync_v504", int'(vc), 504);
      chk("vsync_504", int'(vs_n), 0);
    end
  endtask

  task automatic run_tick(int g);
    int nx;
    for (int c = 0; c < g; c++) begin
      if (c == g - 1) begin
        nx = p + 1;
        if (nx >= 19700 && nx <= 20000)
          sel = 2'd1;
        else if (nx >= 12000 && nx <= 12100)
          sel = 2'd0;
        else
          sel = 2'($urandom_range(0, 3));
        solid = 15'($urandom);
        en_n = 1'b0;
      end else begin
        en_n = 1'b1;
      end
      @(posedge clk);
      #1;
      if (c == g - 1) begin
        p++;
        ticked = 1'b1;
        exp_video = vid(p, int'(sel), int'(solid));
        check_all(1'b1);
        pins();
      end else begin
        check_all(1'b0);
      end
    end
  endtask

  initial begin
    p = 0;
    ticked = 1'b0;
    exp_video = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    while (p < END1) run_tick(gap(p));

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    rst_n = 1'b0;
    en_n = 1'b0;
    #1;
    p = 0;
    ticked = 1'b0;
    exp_video = 0;
    check_all(1'b0);
    @(posedge clk);
    #1;
    check_all(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    while (p < 200) run_tick(gap(p));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
